core_seq_ctrl: RTL and testbench

- Multi-cycle control sequencer for the single-issue 64-bit core.
- Fetches 32-bit instructions over a valid/ready instruction-memory port and latches them into a held instruction register.
- Drives the immediate padder, the ALU B-operand mux, the ALU opcode and the register-file write enable.
- Owns the PC, the retired-instruction counter and halt/fault reporting.

---
 rtl/core_seq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
// Multi-cycle control sequencer for the single-issue 64-bit core: fetch, decode,
// execute and write-back sequencing, PC/instret ownership and halt/fault reporting.
module core_seq_ctrl #(
  parameter logic [63:0] RESET_PC      = 64'h0,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_q,
  output logic        imm_sel,
  output logic [1:0]  alu_op,
  output logic [4:0]  rf_raddr,
  output logic [4:0]  rf_waddr,
  output logic        rf_we,
  output logic [63:0] pc,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  fault
);

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TMO_W   = 8;
  localparam int unsigned OPC_W   = 9;
  localparam int unsigned ALU_W   = 2;
  localparam int unsigned FAULT_W = 2;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FETCH_TIMEOUT - 1);

  localparam logic [OPC_W-1:0] OPC_MOVZ = 9'b110100101;
  localparam logic [OPC_W-1:0] OPC_ADDI = 9'b100100001;
  localparam logic [OPC_W-1:0] OPC_SUBI = 9'b110100010;
  localparam logic [ILEN-1:0]  INSN_HLT = 32'hD440_0000;

  localparam logic [ALU_W-1:0] ALU_PASS_B = 2'b00;
  localparam logic [ALU_W-1:0] ALU_ADD    = 2'b01;
  localparam logic [ALU_W-1:0] ALU_SUB    = 2'b10;

  localparam logic [FAULT_W-1:0] FAULT_NONE    = 2'b00;
  localparam logic [FAULT_W-1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [FAULT_W-1:0] FAULT_TIMEOUT = 2'b10;

  localparam logic [XLEN-1:0] PC_STEP = 64'd4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [TMO_W-1:0]   tmo_cnt_d;
  logic [ILEN-1:0]    instr_d;
  logic [XLEN-1:0]    pc_d;
  logic [CNT_W-1:0]   instret_d;
  logic               imem_req_d;
  logic               rf_we_d;
  logic               imm_sel_d;
  logic [ALU_W-1:0]   alu_op_d;
  logic               halted_d;
  logic [FAULT_W-1:0] fault_d;
  logic [OPC_W-1:0]   opcode;

  assign opcode    = instr_q[31:23];
  assign imem_addr = pc;
  assign rf_raddr  = instr_q[9:5];
  assign rf_waddr  = instr_q[4:0];

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tmo_cnt  <= '0;
      instr_q  <= '0;
      pc       <= RESET_PC;
      instret  <= '0;
      imem_req <= 1'b0;
      rf_we    <= 1'b0;
      imm_sel  <= 1'b0;
      alu_op   <= ALU_PASS_B;
      halted   <= 1'b0;
      fault    <= FAULT_NONE;
    end else begin
      state    <= state_d;
      tmo_cnt  <= tmo_cnt_d;
      instr_q  <= instr_d;
      pc       <= pc_d;
      instret  <= instret_d;
      imem_req <= imem_req_d;
      rf_we    <= rf_we_d;
      imm_sel  <= imm_sel_d;
      alu_op   <= alu_op_d;
      halted   <= halted_d;
      fault    <= fault_d;
    end
  end

  // Next-state logic; decode outputs are zero unless the next state is EXEC or WB.
  always_comb begin
    state_d   = state;
    tmo_cnt_d = tmo_cnt;
    instr_d   = instr_q;
    pc_d      = pc;
    instret_d = instret;
    imm_sel_d = 1'b0;
    alu_op_d  = ALU_PASS_B;
    fault_d   = fault;

    unique case (state)
      S_IDLE: begin
        tmo_cnt_d = '0;
        if (run) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (imem_ready) begin
          instr_d   = imem_rdata;
          tmo_cnt_d = '0;
          state_d   = S_DECODE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_cnt_d = '0;
          fault_d   = FAULT_TIMEOUT;
          state_d   = S_HALT;
        end else begin
          tmo_cnt_d = tmo_cnt + TMO_W'(1);
        end
      end

      S_DECODE: begin
        case (opcode)
          OPC_MOVZ: begin
            alu_op_d  = ALU_PASS_B;
            imm_sel_d = 1'b1;
            state_d   = S_EXEC;
          end
          OPC_ADDI: begin
            alu_op_d  = ALU_ADD;
            imm_sel_d = 1'b1;
            state_d   = S_EXEC;
          end
          OPC_SUBI: begin
            alu_op_d  = ALU_SUB;
            imm_sel_d = 1'b1;
            state_d   = S_EXEC;
          end
          default: begin
            fault_d = (instr_q == INSN_HLT) ? FAULT_NONE : FAULT_ILLEGAL;
            state_d = S_HALT;
          end
        endcase
      end

      S_EXEC: begin
        alu_op_d  = alu_op;
        imm_sel_d = imm_sel;
        state_d   = S_WB;
      end

      S_WB: begin
        pc_d      = pc + PC_STEP;
        instret_d = instret + CNT_W'(1);
        state_d   = run ? S_FETCH : S_IDLE;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered versions of the state being entered.
    imem_req_d = (state_d == S_FETCH);
    rf_we_d    = (state_d == S_WB);
    halted_d   = halted | (state_d == S_HALT);
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: single MOVZ, short program, delayed ready,
// fetch timeout, illegal opcode, run drop in EXEC and reset during FETCH.
module tb_core_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_q;
  logic        imm_sel;
  logic [1:0]  alu_op;
  logic [4:0]  rf_raddr;
  logic [4:0]  rf_waddr;
  logic        rf_we;
  logic [63:0] pc;
  logic [31:0] instret;
  logic        halted;
  logic [1:0]  fault;

  int checks = 0;
  int passed = 0;

  localparam logic [31:0] I_MOVZ = 32'hD280_0540;
  localparam logic [31:0] I_ADDI = 32'h9080_0421;
  localparam logic [31:0] I_SUBI = 32'hD100_0842;
  localparam logic [31:0] I_HLT  = 32'hD440_0000;
  localparam logic [31:0] I_BAD  = 32'hFFFF_FFFF;

  core_seq_ctrl #(.RESET_PC(64'h0), .FETCH_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr_q(instr_q), .imm_sel(imm_sel), .alu_op(alu_op),
    .rf_raddr(rf_raddr), .rf_waddr(rf_waddr), .rf_we(rf_we), .pc(pc),
    .instret(instret), .halted(halted), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d passed=%0d", checks, passed);
    $fatal(1);
  end

  // One clock; sample point is 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Waits (bounded) for imem_req, holds ready low for dly cycles, then returns instr.
  task automatic serve_fetch(input logic [31:0] instr, input int dly, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) begin ok = 1'b1; break; end
      tick();
    end
    if (ok) begin
      repeat (dly) tick();
      imem_ready = 1'b1;
      imem_rdata = instr;
      tick();
      imem_ready = 1'b0;
      imem_rdata = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    #3;
    checks++; if ({imem_req, rf_we, imm_sel, alu_op, halted, fault} !== 8'b0)
      $display("FAIL reset_strobes got %b exp 0", {imem_req, rf_we, imm_sel, alu_op, halted, fault}); else passed++;
    checks++; if ({pc, instret, instr_q} !== 128'b0)
      $display("FAIL reset_regs got pc=%0h instret=%0d instr=%0h exp 0", pc, instret, instr_q); else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0)
      $display("FAIL reset_idle_noreq got %b exp 0", imem_req); else passed++;
  endtask

  task automatic test_single_movz();
    bit ok;
    int lat;
    apply_reset();
    run = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0)
      $display("FAIL movz_req got req=%b addr=%0h exp 1/0", imem_req, imem_addr); else passed++;
    imem_ready = 1'b1; imem_rdata = I_MOVZ;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      imem_ready = 1'b0; imem_rdata = '0;
      lat++;
      if (rf_we) break;
    end
    checks++; if (lat !== 3)
      $display("FAIL movz_we_latency got %0d edges exp 3 (4th cycle of instruction)", lat); else passed++;
    checks++; if (rf_waddr !== 5'd0 || alu_op !== 2'b00 || imm_sel !== 1'b1)
      $display("FAIL movz_wb_ctl got waddr=%0d op=%b imm=%b exp 0/00/1", rf_waddr, alu_op, imm_sel); else passed++;
    checks++; if (rf_raddr !== 5'd10)
      $display("FAIL movz_raddr got %0d exp 10", rf_raddr); else passed++;
    run = 1'b0;
    tick();
    checks++; if (pc !== 64'd4 || instret !== 32'd1 || rf_we !== 1'b0)
      $display("FAIL movz_retire got pc=%0h instret=%0d we=%b exp 4/1/0", pc, instret, rf_we); else passed++;
    ok = 1'b1;
  endtask

  task automatic test_program();
    bit ok;
    logic [31:0] prog [3];
    logic [1:0]  exp_op [3];
    logic [4:0]  exp_rd [3];
    prog = '{I_MOVZ, I_ADDI, I_SUBI};
    exp_op = '{2'b00, 2'b01, 2'b10};
    exp_rd = '{5'd0, 5'd1, 5'd2};
    apply_reset();
    run = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_addr !== 64'(4 * k))
        $display("FAIL prog_addr%0d got %0h exp %0h", k, imem_addr, 4 * k); else passed++;
      serve_fetch(prog[k], 0, ok);
      checks++; if (!ok) $display("FAIL prog_fetch%0d got no_req exp req", k); else passed++;
      tick();
      checks++; if (alu_op !== exp_op[k] || imm_sel !== 1'b1)
        $display("FAIL prog_exec%0d got op=%b imm=%b exp %b/1", k, alu_op, imm_sel, exp_op[k]); else passed++;
      tick();
      checks++; if (rf_we !== 1'b1 || alu_op !== exp_op[k] || rf_waddr !== exp_rd[k])
        $display("FAIL prog_wb%0d got we=%b op=%b rd=%0d exp 1/%b/%0d", k, rf_we, alu_op, rf_waddr, exp_op[k], exp_rd[k]); else passed++;
      tick();
      checks++; if (alu_op !== 2'b00 || imm_sel !== 1'b0)
        $display("FAIL prog_fetch_clr%0d got op=%b imm=%b exp 00/0", k, alu_op, imm_sel); else passed++;
    end
    serve_fetch(I_HLT, 0, ok);
    checks++; if (!ok) $display("FAIL prog_fetch_hlt got no_req exp req"); else passed++;
    tick();
    repeat (3) tick();
    checks++; if (halted !== 1'b1 || fault !== 2'b00)
      $display("FAIL prog_halt got halted=%b fault=%b exp 1/00", halted, fault); else passed++;
    checks++; if (pc !== 64'd12 || instret !== 32'd3)
      $display("FAIL prog_counters got pc=%0h instret=%0d exp c/3", pc, instret); else passed++;
    checks++; if (imem_req !== 1'b0 || rf_we !== 1'b0)
      $display("FAIL prog_halt_quiet got req=%b we=%b exp 0/0", imem_req, rf_we); else passed++;
  endtask

  task automatic test_ready_delay();
    int bad;
    apply_reset();
    run = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req !== 1'b1 || imem_addr !== 64'h0) bad++;
      tick();
    end
    checks++; if (bad !== 0 || imem_req !== 1'b1)
      $display("FAIL delay_stable got %0d unstable cycles req=%b exp 0/1", bad, imem_req); else passed++;
    imem_ready = 1'b1; imem_rdata = I_MOVZ;
    tick();
    imem_ready = 1'b0; imem_rdata = '0; run = 1'b0;
    repeat (3) tick();
    checks++; if (instret !== 32'd1 || pc !== 64'd4 || halted !== 1'b0 || fault !== 2'b00)
      $display("FAIL delay_retire got instret=%0d pc=%0h halted=%b fault=%b exp 1/4/0/00", instret, pc, halted, fault); else passed++;
  endtask

  task automatic test_timeout();
    int we_seen;
    apply_reset();
    run = 1'b1;
    tick();
    we_seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rf_we) we_seen++;
    end
    checks++; if (halted !== 1'b0 || imem_req !== 1'b1)
      $display("FAIL tmo_early got halted=%b req=%b after 15 cycles exp 0/1", halted, imem_req); else passed++;
    tick();
    checks++; if (halted !== 1'b1 || fault !== 2'b10 || imem_req !== 1'b0)
      $display("FAIL tmo_halt got halted=%b fault=%b req=%b exp 1/10/0", halted, fault, imem_req); else passed++;
    repeat (3) begin tick(); if (rf_we) we_seen++; end
    checks++; if (we_seen !== 0 || instret !== 32'd0)
      $display("FAIL tmo_no_we got we_count=%0d instret=%0d exp 0/0", we_seen, instret); else passed++;
  endtask

  task automatic test_illegal();
    bit ok;
    int we_seen;
    apply_reset();
    run = 1'b1;
    tick();
    serve_fetch(I_BAD, 0, ok);
    checks++; if (!ok) $display("FAIL ill_fetch got no_req exp req"); else passed++;
    we_seen = 0;
    repeat (4) begin tick(); if (rf_we) we_seen++; end
    checks++; if (halted !== 1'b1 || fault !== 2'b01)
      $display("FAIL ill_fault got halted=%b fault=%b exp 1/01", halted, fault); else passed++;
    checks++; if (we_seen !== 0 || pc !== 64'h0 || instret !== 32'd0)
      $display("FAIL ill_noretire got we=%0d pc=%0h instret=%0d exp 0/0/0", we_seen, pc, instret); else passed++;
  endtask

  task automatic test_run_drop_and_reset();
    bit ok;
    apply_reset();
    run = 1'b1;
    tick();
    serve_fetch(I_MOVZ, 0, ok);
    tick();
    run = 1'b0;
    tick();
    checks++; if (rf_we !== 1'b1)
      $display("FAIL drop_wb got we=%b exp 1", rf_we); else passed++;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0 || pc !== 64'd4 || instret !== 32'd1)
      $display("FAIL drop_idle got req=%b pc=%0h instret=%0d exp 0/4/1", imem_req, pc, instret); else passed++;
    run = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'd4)
      $display("FAIL drop_resume got req=%b addr=%0h exp 1/4", imem_req, imem_addr); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || pc !== 64'h0 || instret !== 32'd0 || instr_q !== 32'd0)
      $display("FAIL async_reset got req=%b pc=%0h instret=%0d instr=%0h exp 0/0/0/0", imem_req, pc, instret, instr_q); else passed++;
    tick();
    rst_n = 1'b1;
    run = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    test_reset();
    test_single_movz();
    test_program();
    test_ready_delay();
    test_timeout();
    test_illegal();
    test_run_drop_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
